// File: rtl/exc_pkg.sv
// exc_pkg: shared types and helpers for the exception unit.
package exc_pkg;
    localparam int VEC_ENTRY_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEC_REQ,
        S_VEC_WAIT,
        S_REDIRECT,
        S_RETURN
    } exc_state_t;

    // Big-endian byte lane: lane 0 is the most significant byte of the word.
    function automatic logic [VEC_ENTRY_W-1:0] vec_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[31 - VEC_ENTRY_W*lane -: VEC_ENTRY_W];
    endfunction
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: lowest-index-first priority encoder.
module exc_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);
    always_comb begin
        valid  = |req;
        onehot = req & (~req + N'(1));
        idx    = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
endmodule

// File: rtl/exception_unit.sv
// exception_unit: prioritised, maskable exception controller with vector-table fetch and eret.
module exception_unit import exc_pkg::*; #(
    parameter int DATA_W     = 32,
    parameter int NUM_CAUSES = 4,
    parameter int VEC_BASE   = 252
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CAUSES-1:0] cause_req,
    input  logic [DATA_W-1:0]     epc_in,
    input  logic                  mask_we,
    input  logic [NUM_CAUSES-1:0] mask_wdata,
    input  logic                  eret,
    output logic                  mem_req,
    output logic [DATA_W-1:0]     mem_addr,
    input  logic                  mem_gnt,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  cpu_stall,
    output logic                  redirect_valid,
    output logic [DATA_W-1:0]     redirect_pc,
    output logic [DATA_W-1:0]     epc,
    output logic [DATA_W-1:0]     cause,
    output logic                  in_service
);
    localparam int IW = NUM_CAUSES > 1 ? $clog2(NUM_CAUSES) : 1;

    exc_state_t            state_q, state_d;
    logic [NUM_CAUSES-1:0] pending_q, pending_d, mask_q, mask_d, eligible, onehot;
    logic [DATA_W-1:0]     epc_q, epc_d, cause_q, cause_d, rpc_q, rpc_d;
    logic                  in_service_q, in_service_d, sel_valid, take, ret;
    logic [IW-1:0]         sel_idx;

    assign eligible = (pending_q | cause_req) & ~mask_q;

    exc_prio_enc #(.N(NUM_CAUSES), .IW(IW)) u_enc (
        .req    (eligible),
        .valid  (sel_valid),
        .idx    (sel_idx),
        .onehot (onehot)
    );

    always_comb begin
        take         = state_q == S_IDLE && sel_valid && !in_service_q && !eret;
        ret          = state_q == S_IDLE && eret && in_service_q;
        pending_d    = (pending_q | cause_req) & ~(take ? onehot : '0);
        mask_d       = mask_we ? mask_wdata : mask_q;
        epc_d        = take ? epc_in : epc_q;
        cause_d      = take ? DATA_W'(sel_idx) : cause_q;
        // Vector byte arrives in VEC_WAIT; eret reuses the same register for the EPC.
        rpc_d        = state_q == S_VEC_WAIT ? DATA_W'(vec_byte(mem_rdata[31:0], cause_q[1:0])) :
                       ret ? epc_q : rpc_q;
        in_service_d = state_q == S_REDIRECT ? 1'b1 : state_q == S_RETURN ? 1'b0 : in_service_q;
        case (state_q)
            S_IDLE:     state_d = ret ? S_RETURN : take ? S_VEC_REQ : S_IDLE;
            S_VEC_REQ:  state_d = mem_gnt ? S_VEC_WAIT : S_VEC_REQ;
            S_VEC_WAIT: state_d = S_REDIRECT;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            mask_q       <= '0;
            epc_q        <= '0;
            cause_q      <= '0;
            rpc_q        <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            rpc_q        <= rpc_d;
            in_service_q <= in_service_d;
        end
    end

    assign mem_req        = state_q == S_VEC_REQ;
    assign mem_addr       = mem_req ? DATA_W'(VEC_BASE) + (cause_q & ~DATA_W'(3)) : '0;
    assign cpu_stall      = state_q != S_IDLE || take || ret;
    assign redirect_valid = state_q == S_REDIRECT || state_q == S_RETURN;
    assign redirect_pc    = rpc_q;
    assign epc            = epc_q;
    assign cause          = cause_q;
    assign in_service     = in_service_q;
endmodule

// File: doc/exception_unit.md
# exception_unit

Parametrised exception/interrupt controller for the multicycle MIPS core, generalising the fixed two-cause EPC/Cause/vector-byte logic to NUM_CAUSES prioritised, maskable sources. It latches requests, captures EPC and Cause, and fetches the handler address from a byte-packed vector table through a shared memory port. It then redirects the PC and supports return-from-exception. It sits beside the control unit: the control unit stalls on `cpu_stall` and loads `redirect_pc` into PC on `redirect_valid`.

## Interface
Parameters:
- DATA_W, 32, datapath/address width
- NUM_CAUSES, 4, number of cause sources (1..32)
- VEC_BASE, 252, byte address of first vector-table word (multiple of 4)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cause_req  in  NUM_CAUSES  one-cycle request pulses; bit 0 is highest priority
- epc_in  in  DATA_W  resume address, sampled on acceptance
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  NUM_CAUSES  new mask; 1 = cause blocked
- eret  in  1  return-from-exception pulse
- mem_req  out  1  vector-table read request
- mem_addr  out  DATA_W  word address of the vector read
- mem_gnt  in  1  grant; read data is valid the cycle after grant
- mem_rdata  in  DATA_W  memory read data
- cpu_stall  out  1  core must hold state
- redirect_valid  out  1  one-cycle PC load strobe
- redirect_pc  out  DATA_W  new PC value
- epc  out  DATA_W  EPC register
- cause  out  DATA_W  Cause register: cause index, zero-extended
- in_service  out  1  handler running

Clock and reset: single clock `clock`; reset `reset` is synchronous and active-high.

## Operation
- Pending register: `pending <= (pending | cause_req) & ~taken_onehot`. Masked requests stay pending until unmasked or reset.
- Eligible set: `(pending | cause_req) & ~mask`. The selected index is the lowest set bit.
- States: IDLE, VEC_REQ, VEC_WAIT, REDIRECT, RETURN.
- IDLE, with eligible ≠ 0, in_service = 0 and eret = 0:
  - capture epc ← epc_in and cause ← idx;
  - clear that pending bit (including a same-cycle cause_req bit);
  - go to VEC_REQ.
- VEC_REQ:
  - mem_req = 1;
  - mem_addr = VEC_BASE + 4·(idx >> 2);
  - on mem_gnt go to VEC_WAIT, otherwise hold.
- VEC_WAIT:
  - select byte lane k = idx[1:0], big-endian: bits [31−8k : 24−8k];
  - load redirect_pc ← zero-extended byte;
  - go to REDIRECT.
- REDIRECT: redirect_valid = 1; set in_service; go to IDLE.
- IDLE with eret = 1 and in_service = 1:
  - go to RETURN;
  - RETURN drives redirect_valid = 1 and redirect_pc = epc, clears in_service, goes to IDLE.
- eret while in_service = 0: ignored.
- eret and an eligible request in the same cycle: eret wins; the request remains pending.
- Requests during service or during the fetch are only latched in pending; there is no nesting.
- mask_we writes the mask at the clock edge. The same-cycle selection uses the old mask.
- cpu_stall = 1 in VEC_REQ, VEC_WAIT, REDIRECT and RETURN, and in the IDLE cycle where an exception or eret is accepted.

## Timing
- Reset values: all outputs 0; mask 0 (all causes enabled); pending 0; state IDLE.
- Reset mid-fetch: the state is IDLE on the next cycle and mem_req drops immediately after the edge. The in-flight read is ignored.
- Exception latency with immediate grant:
  - request in cycle n (IDLE);
  - VEC_REQ in n+1;
  - VEC_WAIT in n+2;
  - redirect_valid in n+3.
- Each cycle without mem_gnt adds one cycle.
- eret latency: eret in cycle n → redirect_valid with epc in n+1.
- redirect_valid is exactly one cycle wide. redirect_pc holds its value until the next redirect.
- mem_addr is stable whenever mem_req = 1.

## Structure
- Package `exc_pkg` holds:
  - the state enum `exc_state_t`;
  - the lane-select function `vec_byte(word, lane)`;
  - the localparam for vector entry width (8).
- Sub-module `exc_prio_enc`: parametrised lowest-index-first encoder with `valid`, `idx` and `onehot` outputs.

## Test plan
- **Basic vectoring:** cause_req=4'b0100 and epc_in=0x40 in IDLE, mem_gnt held 1, mem_rdata=0x11223344.
  - Expect redirect_valid at n+3 with redirect_pc=0x33, epc=0x40, cause=2, mem_addr=252.
- **Priority:** cause_req=4'b1010.
  - Expect cause=1 serviced first and pending bit 3 retained.
  - After eret, cause 3 is taken with redirect_pc = lane-3 byte.
- **Mask:** mask_wdata=4'b0001, then cause_req=4'b0001.
  - Expect no mem_req.
  - Unmasking starts service the next cycle.
- **Grant stall:** mem_gnt low for 3 cycles in VEC_REQ.
  - Expect mem_req and mem_addr stable throughout.
  - Expect redirect at n+6.
- **eret:** in_service=1, epc=0x80, pulse eret.
  - Expect redirect_pc=0x80 the next cycle and in_service cleared.
  - Also check eret with in_service=0, which must be ignored.
- **Reset in VEC_WAIT:**
  - Expect all outputs 0 and no redirect_valid.
  - A request after reset is serviced normally.
